elm_weight_loader: RTL and testbench
====================================

Name: elm_weight_loader

Overview:
- Transmitter side of the neuron configuration bus.
- Accepts a packed AXI-Stream of weights and biases for one hidden layer.
- Serialises that stream onto the broadcast signals every neuron listens to: weightValue/weightValid, biasValue/biasValid, config_layer_num, config_neuron_num.
- Sits between the AXI DMA/stream front-end and the neuron array; it replaces ad-hoc testbench drivers of the config bus.

Parameters:
- DATA_WIDTH, `dataWidth, width of weight/bias words and of s_axis_tdata.
- LAYER_NO, 1, layer number driven on config_layer_num while loading; must be ≥1.
- NUM_NEURONS, 30, neurons in the layer.
- NUM_WEIGHT, 128, weights per neuron.
- CFG_WIDTH, 2*`dataWidth+1, width of config_layer_num and config_neuron_num.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; arms a layer load
- s_axis_tdata  in  DATA_WIDTH  weight/bias word, two's complement
- s_axis_tvalid  in  1  stream valid
- s_axis_tready  out  1  stream ready
- s_axis_tlast  in  1  marks the final word of the layer
- weightValue  out  DATA_WIDTH  weight word to neurons
- weightValid  out  1  weightValue qualifier
- biasValue  out  DATA_WIDTH  bias word to neurons
- biasValid  out  1  biasValue qualifier
- config_layer_num  out  CFG_WIDTH  target layer
- config_neuron_num  out  CFG_WIDTH  target neuron index
- busy  out  1  load in progress
- done  out  1  one-cycle pulse on successful completion
- err  out  1  sticky framing error

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
  - config_layer_num=0 in IDLE/DONE/ERR, so no neuron matches (layers number from 1).
- Stream order per neuron: NUM_WEIGHT weight words, then 1 bias word. Neurons go 0..NUM_NEURONS-1. Total words = NUM_NEURONS*(NUM_WEIGHT+1).
- A beat is accepted when s_axis_tvalid & s_axis_tready.
- Bus outputs are registered, latency 1: a beat accepted at cycle N produces a valid pulse at N+1. On that cycle weightValue/biasValue and config_*_num are stable and belong to the same neuron.
- weightValid and biasValid are single-cycle per beat and never high together. Value registers hold their last word when not valid.
- States:
  - IDLE: tready=0. start → WEIGHTS; w_cnt=0, n_cnt=0, err cleared.
  - WEIGHTS: tready=1. Each accepted beat emits weightValid and increments w_cnt. Beat with w_cnt==NUM_WEIGHT-1 → BIAS, w_cnt=0.
  - BIAS: tready=1. Accepted beat emits biasValid.
    - If n_cnt==NUM_NEURONS-1 → DONE.
    - Otherwise n_cnt++ and → WEIGHTS.
  - DONE: one cycle; done=1, tready=0 → IDLE.
  - ERR: tready=1; drains and discards beats without emitting valids. Accepted beat with tlast → IDLE; err stays 1.
- config_layer_num=LAYER_NO and config_neuron_num=n_cnt (zero-extended) in WEIGHTS/BIAS and on the output cycle following the final beat.
- busy=1 in WEIGHTS, BIAS, ERR.
- Framing errors (checked on accepted beats):
  - tlast on any beat other than the final bias → err=1.
    - That beat is still emitted, since the neurons already own earlier words.
    - Then → IDLE; no done.
  - Final bias beat without tlast → err=1; the beat is emitted; → ERR to drain to tlast; no done.
- start while busy: ignored. start in the DONE cycle: ignored.
- start coincident with rst: rst wins.
- rst mid-load: immediate return to IDLE with all outputs 0. The next cycle carries no valid pulse even if a beat was accepted the cycle before.
- tvalid gaps: no bus activity; counters hold.
- Counter widths: $clog2(NUM_WEIGHT) and $clog2(NUM_NEURONS), min 1 bit. No wrap beyond terminal counts.

Decomposition:
- Shared include: `dataWidth and a new `cfgWidth (2*`dataWidth+1).
- State encoding localparams live in the module.
- One natural sub-module: elm_cfg_framer. It holds the w_cnt/n_cnt counters and terminal-count/tlast checks and outputs last_weight, last_bias, frame_err.
- The top holds the FSM, skid-free registered bus outputs and the AXI handshake.

Test Plan (NUM_WEIGHT=4, NUM_NEURONS=2, LAYER_NO=1):
- Nominal: start, then 10 back-to-back beats 0x0001..0x000A with tlast on beat 10.
  - weightValid carries 1–4 with neuron_num=0, then biasValid 5.
  - weightValid carries 6–9 with neuron_num=1, then biasValid 10.
  - done pulses the cycle after the last emission; err=0.
- Throttled: same data with tvalid low every other cycle → identical value/neuron sequence; no valid on gap cycles.
- Early tlast on beat 7:
  - beats 1–7 emitted;
  - err=1, no done, back to IDLE; tready=0 afterwards.
- Missing tlast: 10 beats without tlast, then 2 extra beats, tlast on the second.
  - 10 emissions only; err=1; ERR drains both extra beats; IDLE; no done.
- Reset at beat 3: rst high one cycle.
  - All outputs 0 the next cycle; config_layer_num=0.
  - A subsequent start plus a full 10-beat load completes with done.
- start while busy at beat 5: sequence is unaffected, single done.

Source files
------------

// File: rtl/elm_weight_loader_pkg.sv
// Shared types and constants for the neuron configuration bus loader.
// Defines the default widths, the FSM state type and a counter-width helper.
package elm_weight_loader_pkg;

  localparam int DATA_WIDTH_DEF = 16;
  localparam int CFG_WIDTH_DEF  = 2*DATA_WIDTH_DEF+1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WEIGHTS,
    ST_BIAS,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/elm_cfg_framer.sv
// Weight/neuron position counters and framing checks for one layer load.
// Flags the last weight, the last bias and any misplaced or missing tlast.
module elm_cfg_framer
  import elm_weight_loader_pkg::*;
#(
  parameter  int NUM_NEURONS = 30,
  parameter  int NUM_WEIGHT  = 128,
  localparam int WB = cnt_w(NUM_WEIGHT),
  localparam int NB = cnt_w(NUM_NEURONS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          take_w,
  input  logic          take_b,
  input  logic          tlast,
  output logic          last_weight,
  output logic          last_bias,
  output logic          frame_err,
  output logic [NB-1:0] n_cnt,
  output logic [NB-1:0] n_nxt
);

  logic [WB-1:0] w_cnt;

  assign last_weight = (w_cnt == WB'(NUM_WEIGHT-1));
  assign last_bias   = (n_cnt == NB'(NUM_NEURONS-1));

  // tlast belongs only on the final bias; anywhere else, or absent there, is an error
  assign frame_err = (take_w & tlast) | (take_b & (last_bias ^ tlast));

  // neuron index as it will be after this cycle
  always_comb begin
    n_nxt = n_cnt;
    if (clear)
      n_nxt = '0;
    else if (take_b && !last_bias)
      n_nxt = n_cnt + NB'(1);
  end

  // position counters, stopping at their terminal counts
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      w_cnt <= '0;
      n_cnt <= '0;
    end else begin
      if (take_w)
        w_cnt <= last_weight ? '0 : w_cnt + WB'(1);
      if (take_b && !last_bias)
        n_cnt <= n_cnt + NB'(1);
    end
  end

endmodule

// File: rtl/elm_weight_loader.sv
// Serialises a packed weight/bias AXI-Stream onto the neuron config bus.
// FSM, AXI handshake and registered broadcast outputs.
module elm_weight_loader
  import elm_weight_loader_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int LAYER_NO    = 1,
  parameter int NUM_NEURONS = 30,
  parameter int NUM_WEIGHT  = 128,
  parameter int CFG_WIDTH   = CFG_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] weightValue,
  output logic                  weightValid,
  output logic [DATA_WIDTH-1:0] biasValue,
  output logic                  biasValid,
  output logic [CFG_WIDTH-1:0]  config_layer_num,
  output logic [CFG_WIDTH-1:0]  config_neuron_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int NB = cnt_w(NUM_NEURONS);

  state_t        state, state_nxt;
  logic          acc, take_w, take_b, clear, emit, active_nxt;
  logic          last_weight, last_bias, frame_err;
  logic [NB-1:0] n_cnt, n_nxt;

  assign s_axis_tready = (state == ST_WEIGHTS) | (state == ST_BIAS) |
                         (state == ST_ERR);
  assign busy   = s_axis_tready;
  assign acc    = s_axis_tvalid & s_axis_tready;
  assign take_w = acc & (state == ST_WEIGHTS);
  assign take_b = acc & (state == ST_BIAS);
  assign emit   = take_w | take_b;
  assign clear  = (state == ST_IDLE) & start;

  elm_cfg_framer #(
    .NUM_NEURONS (NUM_NEURONS),
    .NUM_WEIGHT  (NUM_WEIGHT)
  ) u_framer (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .take_w      (take_w),
    .take_b      (take_b),
    .tlast       (s_axis_tlast),
    .last_weight (last_weight),
    .last_bias   (last_bias),
    .frame_err   (frame_err),
    .n_cnt       (n_cnt),
    .n_nxt       (n_nxt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start)
          state_nxt = ST_WEIGHTS;
      end
      ST_WEIGHTS: begin
        if (take_w) begin
          if (frame_err)
            state_nxt = ST_IDLE;
          else if (last_weight)
            state_nxt = ST_BIAS;
        end
      end
      ST_BIAS: begin
        if (take_b) begin
          if (last_bias)
            state_nxt = s_axis_tlast ? ST_DONE : ST_ERR;
          else
            state_nxt = s_axis_tlast ? ST_IDLE : ST_WEIGHTS;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      ST_ERR: begin
        if (acc && s_axis_tlast)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign active_nxt = (state_nxt == ST_WEIGHTS) | (state_nxt == ST_BIAS);

  // registered broadcast bus; the neuron index travels with its word
  always_ff @(posedge clk) begin
    if (rst) begin
      weightValue       <= '0;
      weightValid       <= 1'b0;
      biasValue         <= '0;
      biasValid         <= 1'b0;
      config_layer_num  <= '0;
      config_neuron_num <= '0;
      done              <= 1'b0;
      err               <= 1'b0;
    end else begin
      weightValid <= take_w;
      biasValid   <= take_b;
      if (take_w)
        weightValue <= s_axis_tdata;
      if (take_b)
        biasValue <= s_axis_tdata;
      config_layer_num <= (emit || active_nxt) ?
                          CFG_WIDTH'(LAYER_NO) : '0;
      if (emit)
        config_neuron_num <= CFG_WIDTH'(n_cnt);
      else if (active_nxt)
        config_neuron_num <= CFG_WIDTH'(n_nxt);
      else
        config_neuron_num <= '0;
      done <= (state == ST_DONE);
      if (clear)
        err <= 1'b0;
      else if (frame_err)
        err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_elm_weight_loader.sv
// Self-checking bench for elm_weight_loader with a 2-neuron, 4-weight layer.
// Expected bus words are queued at drive time and checked as they appear.
module tb_elm_weight_loader;

  localparam int DW = 16;
  localparam int CW = 33;
  localparam int NW = 4;
  localparam int NN = 2;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [DW-1:0] weightValue, biasValue;
  logic          weightValid, biasValid;
  logic [CW-1:0] config_layer_num, config_neuron_num;
  logic          busy, done, err;

  always #5 clk = ~clk;

  elm_weight_loader #(
    .DATA_WIDTH  (DW),
    .LAYER_NO    (1),
    .NUM_NEURONS (NN),
    .NUM_WEIGHT  (NW),
    .CFG_WIDTH   (CW)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .s_axis_tdata      (s_axis_tdata),
    .s_axis_tvalid     (s_axis_tvalid),
    .s_axis_tready     (s_axis_tready),
    .s_axis_tlast      (s_axis_tlast),
    .weightValue       (weightValue),
    .weightValid       (weightValid),
    .biasValue         (biasValue),
    .biasValid         (biasValid),
    .config_layer_num  (config_layer_num),
    .config_neuron_num (config_neuron_num),
    .busy              (busy),
    .done              (done),
    .err               (err)
  );

  typedef struct {
    bit is_bias;
    int value;
    int neuron;
  } exp_t;

  typedef struct {
    string name;
    int    nbeats;
    int    tlast_at;
    int    emit_lim;
    bit    gap;
    int    start_at;
    int    exp_done;
    bit    exp_err;
  } vec_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   last_emit_cyc = 0;

  function automatic void chk(string nm, longint act, longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endfunction

  // scoreboard: every bus pulse must match the oldest queued expectation
  always @(negedge clk) begin
    cyc++;
    if (weightValid && biasValid)
      chk("both_valid", 1, 0);
    if (weightValid || biasValid) begin
      last_emit_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_emit", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("emit_kind", biasValid, e.is_bias);
        chk("emit_value", biasValid ? biasValue : weightValue, e.value);
        chk("emit_neuron", config_neuron_num, e.neuron);
        chk("emit_layer", config_layer_num, 1);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic send(input int k, input bit last, input bit push,
                      input bit st);
    int t;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(k);
    s_axis_tlast  = last;
    start         = st;
    t = 0;
    while (!s_axis_tready && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 20)
      chk("tready_timeout", 0, 1);
    if (push) begin
      exp_t e;
      e.is_bias = (((k-1) % (NW+1)) == NW);
      e.value   = k;
      e.neuron  = (k-1) / (NW+1);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    start         = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    int d0;
    d0 = done_cnt;
    pulse_start();
    @(negedge clk);
    chk({v.name, "_err_cleared"}, err, 0);
    chk({v.name, "_busy"}, busy, 1);
    @(posedge clk);
    #1;
    for (int k = 1; k <= v.nbeats; k++) begin
      if (v.gap && k > 1) begin
        @(posedge clk);
        #1;
      end
      send(k, k == v.tlast_at, k <= v.emit_lim, k == v.start_at);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk({v.name, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    chk({v.name, "_done_cnt"}, done_cnt - d0, v.exp_done);
    if (v.exp_done > 0)
      chk({v.name, "_done_lat"}, done_cyc - last_emit_cyc, 1);
    chk({v.name, "_err"}, err, v.exp_err);
    chk({v.name, "_tready_idle"}, s_axis_tready, 0);
    chk({v.name, "_busy_idle"}, busy, 0);
    chk({v.name, "_layer_idle"}, config_layer_num, 0);
    #1;
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{"nominal",   10, 10, 10, 1'b0, 0, 1, 1'b0};
    vecs[1] = '{"throttled", 10, 10, 10, 1'b1, 0, 1, 1'b0};
    vecs[2] = '{"early",      7,  7,  7, 1'b0, 0, 0, 1'b1};
    vecs[3] = '{"missing",   12, 12, 10, 1'b0, 0, 0, 1'b1};
    vecs[4] = '{"busystart", 10, 10, 10, 1'b0, 5, 1, 1'b0};

    rst = 1'b1;
    start = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_weightValid", weightValid, 0);
    chk("rst_biasValid", biasValid, 0);
    chk("rst_weightValue", weightValue, 0);
    chk("rst_biasValue", biasValue, 0);
    chk("rst_layer", config_layer_num, 0);
    chk("rst_neuron", config_neuron_num, 0);
    chk("rst_tready", s_axis_tready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++)
      run_load(vecs[i]);

    // reset lands together with beat 3: that beat must never appear
    pulse_start();
    send(1, 1'b0, 1'b1, 1'b0);
    send(2, 1'b0, 1'b1, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_axis_tvalid = 1'b0;
    @(negedge clk);
    chk("midrst_weightValid", weightValid, 0);
    chk("midrst_biasValid", biasValid, 0);
    chk("midrst_weightValue", weightValue, 0);
    chk("midrst_layer", config_layer_num, 0);
    chk("midrst_neuron", config_neuron_num, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tready", s_axis_tready, 0);
    chk("midrst_pending", exp_q.size(), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    run_load(vecs[0]);

    // start coincident with reset: reset wins
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rststart_busy", busy, 0);
    chk("rststart_tready", s_axis_tready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
